// File: rtl/as_alu.sv
`default_nettype none
// ============================================================================
// Module      : as_alu
// Description : Datapath ALU with an operand-selectable adder, a Q1.(N-1)
//               fixed-point multiplier, a multiply-accumulate register (ACC),
//               a zero flag and a writeback mux for external switches.
// Revision    : 1.0 - initial release
// ============================================================================
module as_alu #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic [N-1:0] rd_data,
  input  logic [N-1:0] rs_data,
  input  logic [N-1:0] immediate,
  input  logic         add_a_sel,
  input  logic         add_b_sel,
  input  logic [N:0]   switches,
  input  logic         acc_en,
  input  logic         acc_add,
  input  logic         in_en,
  output logic         z,
  output logic [N-1:0] w_data,
  output logic [N-1:0] acc_out
);

  // Full-width signed product; only bits [2N-2:N-1] form the Q1.(N-1) result.
  logic signed [2*N-1:0] product;
  logic [N-1:0]          mult_out;
  logic [N-1:0]          add_a;
  logic [N-1:0]          add_b;
  logic [N-1:0]          add_out;
  // Sign-duplicate top bit and fractional low bits are dropped by truncation.
  logic                  unused_product_bits;

  // Signed multiply, arithmetic shift right by N-1 via bit selection (truncating).
  always_comb begin
    product  = $signed(rs_data) * $signed(immediate);
    mult_out = product[2*N-2:N-1];
  end

  assign unused_product_bits = ^{product[2*N-1], product[N-2:0]};

  // Adder operand selection; MACC mode overrides both individual selectors.
  always_comb begin
    add_a = rd_data;
    add_b = rs_data;
    if (acc_add) begin
      add_a = acc_out;
      add_b = mult_out;
    end else begin
      if (add_a_sel) begin
        add_a = {N{switches[N]}};
      end
      if (add_b_sel) begin
        add_b = immediate;
      end
    end
  end

  // Modulo-2^N add; carry-out intentionally discarded.
  always_comb begin
    add_out = add_a + add_b;
  end

  // Zero flag and writeback mux are purely combinational.
  always_comb begin
    z      = (add_out == '0);
    w_data = in_en ? switches[N-1:0] : add_out;
  end

  // Accumulator: async clear, loads adder result when enabled.
  always_ff @(posedge clk or posedge n_reset) begin
    if (n_reset) begin
      acc_out <= '0;
    end else if (acc_en) begin
      acc_out <= add_out;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_as_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_as_alu
// Description : Directed self-checking bench for as_alu using an expectation
//               queue that is drained after each stimulus step settles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_as_alu;

  localparam int N = 8;

  localparam int K_WDATA = 0;
  localparam int K_Z     = 1;
  localparam int K_ACC   = 2;
  localparam int K_MULT  = 3;

  logic         clk;
  logic         n_reset;
  logic [N-1:0] rd_data;
  logic [N-1:0] rs_data;
  logic [N-1:0] immediate;
  logic         add_a_sel;
  logic         add_b_sel;
  logic [N:0]   switches;
  logic         acc_en;
  logic         acc_add;
  logic         in_en;
  logic         z;
  logic [N-1:0] w_data;
  logic [N-1:0] acc_out;

  typedef struct {
    string      tag;
    int         kind;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   compared;
  int   mismatched;

  as_alu #(.N(N)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .rd_data   (rd_data),
    .rs_data   (rs_data),
    .immediate (immediate),
    .add_a_sel (add_a_sel),
    .add_b_sel (add_b_sel),
    .switches  (switches),
    .acc_en    (acc_en),
    .acc_add   (acc_add),
    .in_en     (in_en),
    .z         (z),
    .w_data    (w_data),
    .acc_out   (acc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record an expectation at the moment the stimulus is driven.
  task automatic expect_val(input string tag, input int kind, input logic [7:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Compare every pending expectation against the current DUT outputs.
  task automatic drain();
    while (sb.size() > 0) begin
      exp_t       e;
      logic [7:0] obs;
      e = sb.pop_front();
      case (e.kind)
        K_WDATA: obs = w_data;
        K_Z:     obs = {7'b0, z};
        K_ACC:   obs = acc_out;
        default: obs = dut.mult_out;
      endcase
      compared++;
      assert (obs === e.val) else begin
        mismatched++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    n_reset = 1'b1;
    #1;
    n_reset = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    n_reset    = 1'b1;
    rd_data    = '0;
    rs_data    = '0;
    immediate  = '0;
    add_a_sel  = 1'b0;
    add_b_sel  = 1'b0;
    switches   = '0;
    acc_en     = 1'b0;
    acc_add    = 1'b0;
    in_en      = 1'b0;

    // Reset state with all inputs zero.
    expect_val("rst_acc", K_ACC, 8'h00);
    expect_val("rst_z", K_Z, 8'h01);
    expect_val("rst_wdata", K_WDATA, 8'h00);
    #1;
    drain();
    @(negedge clk);
    n_reset = 1'b0;

    // Load ACC with rs+imm? no: B=imm, A=rd=0 -> 6.
    add_b_sel = 1'b1; acc_en = 1'b1; rd_data = 8'd0; rs_data = 8'd23; immediate = 8'd6;
    expect_val("load_add", K_WDATA, 8'd6);
    #1; drain();
    @(posedge clk); #1;
    expect_val("load_acc", K_ACC, 8'd6);
    drain();

    // MACC: 6 + (20 * 0.75) = 21.
    @(negedge clk);
    add_b_sel = 1'b0; acc_add = 1'b1; acc_en = 1'b1;
    rd_data = 8'd32; rs_data = 8'd20; immediate = 8'b0110_0000;
    expect_val("macc_mult", K_MULT, 8'd15);
    expect_val("macc_add", K_WDATA, 8'd21);
    #1; drain();
    @(posedge clk); #1;
    expect_val("macc_acc", K_ACC, 8'd21);
    drain();
    @(negedge clk);
    acc_add = 1'b0; acc_en = 1'b0;

    // ADDI writeback and switch input mux.
    pulse_reset();
    add_b_sel = 1'b1; rd_data = 8'd12; rs_data = 8'd13; immediate = 8'd8;
    switches = 9'd30; in_en = 1'b0;
    expect_val("addi_wdata", K_WDATA, 8'd20);
    expect_val("addi_acc_clr", K_ACC, 8'd0);
    #1; drain();
    in_en = 1'b1;
    expect_val("in_en_wdata", K_WDATA, 8'd30);
    #1; drain();
    in_en = 1'b0;

    // Switch sense through A={n{switches[n]}}.
    pulse_reset();
    add_a_sel = 1'b1; add_b_sel = 1'b0; rs_data = 8'd0; switches = 9'h000;
    expect_val("sense_lo_add", K_WDATA, 8'h00);
    expect_val("sense_lo_z", K_Z, 8'h01);
    #1; drain();
    switches = 9'h100;
    expect_val("sense_hi_add", K_WDATA, 8'hFF);
    expect_val("sense_hi_z", K_Z, 8'h00);
    #1; drain();
    add_a_sel = 1'b0; switches = '0;

    // Modulo wrap and zero flag.
    rd_data = 8'd200; rs_data = 8'd100;
    expect_val("wrap_add", K_WDATA, 8'd44);
    expect_val("wrap_z", K_Z, 8'h00);
    #1; drain();
    rd_data = 8'd128; rs_data = 8'd128;
    expect_val("wrap0_add", K_WDATA, 8'd0);
    expect_val("wrap0_z", K_Z, 8'h01);
    #1; drain();

    // Load a nonzero ACC, then check hold with acc_en=0.
    @(negedge clk);
    rd_data = 8'd200; rs_data = 8'd100; acc_en = 1'b1;
    @(posedge clk); #1;
    expect_val("wrap_acc", K_ACC, 8'd44);
    drain();
    acc_en = 1'b0; rd_data = 8'd3; rs_data = 8'd4;
    @(posedge clk); #1;
    expect_val("hold_acc", K_ACC, 8'd44);
    drain();

    // Asynchronous clear mid-cycle, no clock edge in between.
    #1;
    n_reset = 1'b1;
    expect_val("async_clr", K_ACC, 8'd0);
    #1; drain();
    @(negedge clk);
    n_reset = 1'b0;

    // Reset held across a clock edge with acc_en=1 keeps ACC at zero.
    acc_en = 1'b1;
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk); #1;
    expect_val("rst_wins", K_ACC, 8'd0);
    drain();
    @(negedge clk);
    n_reset = 1'b0; acc_en = 1'b0;

    // Signed multiply into empty ACC: -16 * 0.5 = -8.
    acc_add = 1'b1; acc_en = 1'b1; rs_data = 8'hF0; immediate = 8'b0100_0000;
    expect_val("smul_mult", K_MULT, 8'hF8);
    expect_val("smul_add", K_WDATA, 8'hF8);
    #1; drain();
    @(posedge clk); #1;
    expect_val("smul_acc", K_ACC, 8'hF8);
    drain();
    @(negedge clk);
    acc_add = 1'b0; acc_en = 1'b0;
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
